// File: rtl/ppu_pixel_fifo.sv
// ppu_pixel_fifo: background/window pixel FIFO between the BG fetcher and the
// LCD pixel output. Tile rows (one bitplane byte per plane) are pushed whole;
// one colour index (or palette shade) is popped per cycle with one cycle of
// output latency. A flush empties the FIFO and arms a fine-scroll discard.
//
// Build option: define PPU_FIFO_PALETTE_EN to map popped indices through bgp
// (requires BPP == 2). Without it, px_out is the raw colour index.
//
// state   | meaning
// RUN     | popped pixels are visible (px_valid=1)
// DISCARD | popped pixels are dropped until disc_cnt reaches zero

module ppu_pixel_fifo #(
  parameter int DEPTH  = 16,
  parameter int TILE_W = 8,
  parameter int BPP    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [$clog2(TILE_W)-1:0]    fine_scroll,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [BPP*TILE_W-1:0]        push_data,
  input  logic                         pop_en,
  input  logic [7:0]                   bgp,
  output logic [BPP-1:0]               px_out,
  output logic                         px_valid,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         underrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int SW = $clog2(TILE_W);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_DISCARD = 1'b1;

  logic [BPP-1:0] mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [0:0]     state;
  logic [SW-1:0]  disc_cnt;

  logic           push_fire;
  logic           pop_fire;
  logic [LW-1:0]  level_nxt;
  logic [BPP-1:0] pop_pix;
  logic [BPP-1:0] pop_shade;
  logic [BPP-1:0] row_pix [TILE_W];

  // Pointer advance with wrap modulo DEPTH (DEPTH need not be a power of two).
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int unsigned n);
    int unsigned s;
    s = 32'(p) + n;
    if (s >= 32'(DEPTH)) s = s - 32'(DEPTH);
    return PW'(s);
  endfunction

  assign push_ready = (level <= LW'(DEPTH - TILE_W));
  assign push_fire  = push_valid && push_ready && !flush && !rst;
  assign pop_fire   = pop_en && (level != '0) && !flush;
  assign pop_pix    = mem[rd_ptr];

`ifdef PPU_FIFO_PALETTE_EN
  assign pop_shade = bgp[{pop_pix, 1'b0} +: 2];
`else
  logic unused_bgp;
  assign unused_bgp = ^bgp;
  assign pop_shade  = pop_pix;
`endif

  // Unpack a tile row into per-pixel indices, leftmost pixel (MSB) first.
  always_comb begin
    for (int i = 0; i < TILE_W; i++) begin
      for (int p = 0; p < BPP; p++) begin
        row_pix[i][p] = push_data[p*TILE_W + (TILE_W-1-i)];
      end
    end
  end

  // Occupancy after this cycle's push and/or pop.
  always_comb begin
    level_nxt = level;
    case ({push_fire, pop_fire})
      2'b10:   level_nxt = level + LW'(TILE_W);
      2'b01:   level_nxt = level - LW'(1);
      2'b11:   level_nxt = level + LW'(TILE_W - 1);
      default: level_nxt = level;
    endcase
  end

  // Pixel storage: a push writes a whole tile row starting at wr_ptr.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      for (int i = 0; i < TILE_W; i++) begin
        mem[ptr_add(wr_ptr, i)] <= row_pix[i];
      end
    end
  end

  // Pointers, occupancy, discard FSM, registered output and sticky underrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      state    <= ST_RUN;
      disc_cnt <= '0;
      px_out   <= '0;
      px_valid <= 1'b0;
      underrun <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      disc_cnt <= fine_scroll;
      state    <= (fine_scroll != '0) ? ST_DISCARD : ST_RUN;
      px_valid <= 1'b0;
      underrun <= 1'b0;
    end else begin
      px_valid <= 1'b0;
      level    <= level_nxt;
      if (push_fire) wr_ptr <= ptr_add(wr_ptr, TILE_W);
      if (pop_fire) begin
        rd_ptr <= ptr_add(rd_ptr, 1);
        if (state == ST_DISCARD) begin
          disc_cnt <= disc_cnt - SW'(1);
          if (disc_cnt == SW'(1)) state <= ST_RUN;
        end else begin
          px_out   <= pop_shade;
          px_valid <= 1'b1;
        end
      end
      if (pop_en && (level == '0) && (state == ST_RUN)) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ppu_pixel_fifo.sv
// Testbench for ppu_pixel_fifo: directed scenarios followed by random traffic,
// checked by a queue-based reference model and an independent output monitor.

module tb_ppu_pixel_fifo;

  localparam int DEPTH  = 16;
  localparam int TILE_W = 8;
  localparam int BPP    = 2;
`ifdef PPU_FIFO_PALETTE_EN
  localparam bit PAL = 1'b1;
`else
  localparam bit PAL = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    flush = 1'b0;
  logic [2:0]              fine_scroll = '0;
  logic                    push_valid = 1'b0;
  logic                    push_ready;
  logic [BPP*TILE_W-1:0]   push_data = '0;
  logic                    pop_en = 1'b0;
  logic [7:0]              bgp = 8'hE4;
  logic [BPP-1:0]          px_out;
  logic                    px_valid;
  logic [4:0]              level;
  logic                    underrun;

  ppu_pixel_fifo #(.DEPTH(DEPTH), .TILE_W(TILE_W), .BPP(BPP)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fine_scroll(fine_scroll),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_en(pop_en), .bgp(bgp), .px_out(px_out), .px_valid(px_valid),
    .level(level), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a pixel queue, a count of pixels still to discard,
  // the sticky underrun flag and the expected px_valid of the next cycle.
  int model_fifo[$];
  int model_disc = 0;
  bit model_und  = 1'b0;
  bit model_pv   = 1'b0;
  int sb[$];
  bit mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int shade(input int idx, input logic [7:0] b);
    return PAL ? ((int'(b) >> (2*idx)) & 3) : idx;
  endfunction

  function automatic int pix_of(input logic [15:0] d, input int i);
    return int'(d[TILE_W-1-i]) + 2*int'(d[TILE_W + TILE_W-1-i]);
  endfunction

  // Apply the FIFO's rules to the inputs sampled at this clock edge.
  task automatic model_step();
    bit ready;
    int p;
    model_pv = 1'b0;
    if (rst) begin
      model_fifo.delete();
      model_disc = 0;
      model_und  = 1'b0;
    end else if (flush) begin
      model_fifo.delete();
      model_disc = int'(fine_scroll);
      model_und  = 1'b0;
    end else begin
      ready = (model_fifo.size() <= DEPTH - TILE_W);
      if (pop_en && model_fifo.size() != 0) begin
        p = model_fifo.pop_front();
        if (model_disc > 0) model_disc--;
        else begin
          sb.push_back(shade(p, bgp));
          model_pv = 1'b1;
        end
      end else if (pop_en && model_disc == 0) begin
        model_und = 1'b1;
      end
      if (push_valid && ready)
        for (int i = 0; i < TILE_W; i++) model_fifo.push_back(pix_of(push_data, i));
    end
  endtask

  task automatic cycle(input bit r, input bit f, input int fs, input bit pv,
                       input logic [15:0] pd, input bit pe);
    @(negedge clk);
    rst = r; flush = f; fine_scroll = 3'(fs);
    push_valid = pv; push_data = pd; pop_en = pe;
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(); cycle(0, 0, 0, 0, 16'h0, 0); endtask
  task automatic push(input logic [15:0] d); cycle(0, 0, 0, 1, d, 0); endtask
  task automatic pop(); cycle(0, 0, 0, 0, 16'h0, 1); endtask

  // Monitor: compares DUT outputs to the model away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      int e;
      check("level", int'(level), model_fifo.size());
      check("push_ready", int'(push_ready), int'(model_fifo.size() <= DEPTH - TILE_W));
      check("underrun", int'(underrun), int'(model_und));
      check("px_valid", int'(px_valid), int'(model_pv));
      if (px_valid) begin
        if (sb.size() == 0) check("px_valid_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          check("px_out", int'(px_out), e);
        end
      end
    end
  end

  initial begin
    bit r, f, pv, pe;
    cycle(1, 0, 0, 0, 16'h0, 0);
    cycle(1, 0, 0, 0, 16'h0, 0);
    #1;
    check("reset_level", int'(level), 0);
    check("reset_px_valid", int'(px_valid), 0);
    check("reset_px_out", int'(px_out), 0);
    check("reset_push_ready", int'(push_ready), 1);
    check("reset_underrun", int'(underrun), 0);
    mon_en = 1'b1;

    // Tile row decode: expects 2,2,3,3,1,1,0,0
    bgp = 8'hE4;
    push(16'hF03C);
    #1 check("t1_level", int'(level), 8);
    for (int i = 0; i < 8; i++) pop();
    idle();

    // Backpressure at full depth.
    push(16'h1234);
    push(16'h5678);
    #1 check("t2_level_full", int'(level), 16);
    check("t2_ready_full", int'(push_ready), 0);
    push(16'h9ABC);
    #1 check("t2_held_level", int'(level), 16);
    pop();
    #1 check("t2_level_15", int'(level), 15);
    check("t2_ready_15", int'(push_ready), 0);
    for (int i = 0; i < 7; i++) pop();
    #1 check("t2_ready_8", int'(push_ready), 1);
    for (int i = 0; i < 8; i++) pop();
    idle();

    // Fine-scroll discard of 3 then five pixels of index 1.
    cycle(0, 1, 3, 0, 16'h0, 0);
    #1 check("t3_flush_level", int'(level), 0);
    push(16'h00FF);
    for (int i = 0; i < 8; i++) pop();
    idle();

    // Underrun on empty, held, cleared by flush.
    cycle(1, 0, 0, 0, 16'h0, 0);
    pop();
    #1 check("t4_underrun_set", int'(underrun), 1);
    idle();
    #1 check("t4_underrun_held", int'(underrun), 1);
    cycle(0, 1, 0, 0, 16'h0, 0);
    #1 check("t4_underrun_clr", int'(underrun), 0);

    // Simultaneous push/pop, then flush with push and pop asserted.
    push(16'hA5C3);
    for (int i = 0; i < 3; i++) pop();
    #1 check("t5_level_5", int'(level), 5);
    cycle(0, 0, 0, 1, 16'h3C5A, 1);
    #1 check("t5_level_12", int'(level), 12);
    cycle(0, 1, 0, 1, 16'hFFFF, 1);
    #1 check("t5_flush_level", int'(level), 0);

    // Palette mapping: indices 0..3 through two palettes.
    push(16'h3355);
    bgp = 8'hE4;
    for (int i = 0; i < 4; i++) pop();
    bgp = 8'h1B;
    for (int i = 0; i < 4; i++) pop();
    idle();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 39) == 0);
      pv = ($urandom_range(0, 1) == 1);
      pe = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 15) == 0) bgp = 8'($urandom);
      cycle(r, f, int'($urandom_range(0, 7)), pv, 16'($urandom), pe);
    end

    cycle(0, 1, 0, 0, 16'h0, 0);
    idle();
    idle();
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
